// File: rtl/clock_divider.sv
// rtl/clock_divider.sv - programmable 50%-duty clock divider, ratio 2*(IN+1)
//
// Purpose:
//   Derives a slow, glitch-free clock/strobe OUT_CLK from CLK. Each half-period
//   lasts IN+1 CLK cycles, with IN latched at the start of the half-period.
//   OUT_CLK comes straight from a flop, so it has no combinational path from
//   CLK or IN.
//
// Ports:
//   CLK      in   1      system clock, rising edge
//   RST      in   1      synchronous active-high reset
//   IN       in   DIV_W  divisor select, half-period = IN+1 cycles
//   OUT_CLK  out  1      divided clock, registered
//   TICK     out  1      single-cycle pulse on each OUT_CLK rise
//                        (present only when CLKDIV_TICK_EN is defined)
//
// Build option:
//   CLKDIV_TICK_EN - adds the TICK output and its flop.

module clock_divider #(
  parameter int DIV_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] IN,
`ifdef CLKDIV_TICK_EN
  output logic             TICK,
`endif
  output logic             OUT_CLK
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic             terminal;

  // cnt counts up from 0 and stops at div, so equality is the only
  // terminal condition needed.
  assign terminal = (cnt == div);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      OUT_CLK <= 1'b0;
      div     <= IN;
    end else if (terminal) begin
      cnt     <= '0;
      OUT_CLK <= ~OUT_CLK;
      // IN is only sampled here, so a mid-half-period change cannot
      // shorten the half-period already in progress.
      div     <= IN;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

`ifdef CLKDIV_TICK_EN
  // Fires on the edge where OUT_CLK goes 0->1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      TICK <= 1'b0;
    end else begin
      TICK <= terminal && !OUT_CLK;
    end
  end
`endif

endmodule

// File: tb/tb_clock_divider.sv
// tb/tb_clock_divider.sv - scoreboard bench for clock_divider with edge-schedule model

module tb_clock_divider;

  localparam int DIV_W = 4;
  localparam int MAXV  = (1 << DIV_W) - 1;

  logic             CLK;
  logic             RST;
  logic [DIV_W-1:0] IN;
  logic             OUT_CLK;
  logic             tick_w;

  typedef struct {
    logic out;
    logic tick;
    int   idx;
  } exp_t;

  exp_t exp_q[$];

  int checks;
  int failures;
  int step_idx;

  // Reference model: edges counted since the last reset edge; OUT_CLK flips
  // on a scheduled edge number and the next flip is scheduled IN+1 edges on.
  int   edge_n;
  int   next_toggle;
  logic level;

  clock_divider #(.DIV_W(DIV_W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .IN      (IN),
`ifdef CLKDIV_TICK_EN
    .TICK    (tick_w),
`endif
    .OUT_CLK (OUT_CLK)
  );

`ifndef CLKDIV_TICK_EN
  assign tick_w = 1'b0;
`endif

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  // Drive one edge worth of inputs, predict the response, push it once the
  // edge has happened.
  task automatic step(input logic r, input logic [DIV_W-1:0] v);
    exp_t e;
    logic rose;
    RST  = r;
    IN   = v;
    rose = 1'b0;
    if (r) begin
      edge_n      = 0;
      level       = 1'b0;
      next_toggle = int'(v) + 1;
    end else begin
      edge_n = edge_n + 1;
      if (edge_n == next_toggle) begin
        level       = ~level;
        rose        = level;
        next_toggle = edge_n + int'(v) + 1;
      end
    end
    e.out  = level;
    e.tick = rose;
    e.idx  = step_idx;
    step_idx = step_idx + 1;
    @(posedge CLK);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic run(input int n, input logic [DIV_W-1:0] v);
    for (int i = 0; i < n; i++) step(1'b0, v);
  endtask

  // Monitor: compare DUT outputs away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks = checks + 1;
        if (OUT_CLK !== e.out) begin
          failures = failures + 1;
          $display("FAIL out_clk step=%0d actual=%b required=%b", e.idx, OUT_CLK, e.out);
        end
`ifdef CLKDIV_TICK_EN
        checks = checks + 1;
        if (tick_w !== e.tick) begin
          failures = failures + 1;
          $display("FAIL tick step=%0d actual=%b required=%b", e.idx, tick_w, e.tick);
        end
`endif
      end
    end
  end

  initial begin
    checks      = 0;
    failures    = 0;
    step_idx    = 0;
    edge_n      = 0;
    next_toggle = 1;
    level       = 1'b0;
    RST         = 1'b1;
    IN          = '0;

    // /32: reset for 3 edges, rise at edge 16, fall at edge 32
    for (int i = 0; i < 3; i++) step(1'b1, 4'(MAXV));
    run(70, 4'(MAXV));

    // /2: toggles every edge
    step(1'b1, 4'd0);
    run(8, 4'd0);

    // IN 3 -> 1 two edges into a half-period
    step(1'b1, 4'd3);
    run(6, 4'd3);
    run(12, 4'd1);

    // reset while OUT_CLK is high, IN=5
    step(1'b1, 4'd5);
    run(8, 4'd5);
    step(1'b1, 4'd5);
    run(14, 4'd5);

    // sustained /16 for 10 periods
    step(1'b1, 4'd7);
    run(160, 4'd7);

    // IN=2: rises (and ticks) on edges 3, 9, 15
    step(1'b1, 4'd2);
    run(20, 4'd2);

    // RST held high keeps OUT_CLK low
    for (int i = 0; i < 6; i++) step(1'b1, 4'($urandom_range(0, MAXV)));

    // randomized divisor changes and occasional resets
    for (int i = 0; i < 2500; i++) begin
      logic r;
      logic [DIV_W-1:0] v;
      r = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) v = 4'($urandom_range(0, MAXV));
      else v = IN;
      step(r, v);
    end

    // drain the scoreboard
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge CLK);
    @(negedge CLK);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
